jtag_bsr_chain: RTL



---
 rtl/jtag_bsr_chain.sv | 71 +++++++
 1 files changed

// File: rtl/jtag_bsr_chain.sv
// Boundary-scan register chain sitting between core logic and pads.
// Capture loads pad inputs and core outputs into the chain, and shift
// moves the chain one bit toward bsr_tdo. A rising edge on bsr_update
// copies the chain into the update register, which drives pads and core
// while bsr_mode is high.
module jtag_bsr_chain #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 4
) (
  input  logic             tck,
  input  logic             trst,
  input  logic             bsr_tdi,
  input  logic             bsr_clk,
  input  logic             bsr_shift,
  input  logic             bsr_update,
  input  logic             bsr_mode,
  output logic             bsr_tdo,
  input  logic [N_IN-1:0]  pad_in,
  output logic [N_IN-1:0]  core_in,
  input  logic [N_OUT-1:0] core_out,
  output logic [N_OUT-1:0] pad_out
);

  localparam int N = N_IN + N_OUT;

  logic [N-1:0] r_chain;
  logic [N-1:0] r_upd;
  logic         r_upd_q;
  logic         w_upd_load;

  // Load the update register only on the rising edge of bsr_update.
  // Holding the request high therefore causes no further loads.
  assign w_upd_load = bsr_update & ~r_upd_q;

  // Capture/shift chain. bsr_clk is an enable sampled on tck, not a clock.
  // NOTE: state uses non-blocking assignments so that r_upd below samples
  // the pre-edge chain value even when a shift occurs on the same edge.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_chain <= '0;
    end else if (bsr_clk) begin
      if (bsr_shift) begin
        r_chain <= {bsr_tdi, r_chain[N-1:1]};
      end else begin
        r_chain <= {core_out, pad_in};
      end
    end
  end

  // Update request edge detector and update register.
  always_ff @(posedge tck or posedge trst) begin
    if (trst) begin
      r_upd_q <= 1'b0;
      r_upd   <= '0;
    end else begin
      r_upd_q <= bsr_update;
      if (w_upd_load) begin
        r_upd <= r_chain;
      end
    end
  end

  // Serial out comes straight from the chain LSB with no extra stage.
  assign bsr_tdo = r_chain[0];

  // Test mode substitutes the update register for the functional paths.
  // bsr_mode only selects here, so it never disturbs chain or update state.
  assign pad_out = bsr_mode ? r_upd[N-1:N_IN] : core_out;
  assign core_in = bsr_mode ? r_upd[N_IN-1:0] : pad_in;

endmodule
